// File: rtl/guard_log_reader.sv
// Readout engine for the store-guard circular buffer: walks every slot through the
// buffer read port, streams each word over valid/ready, and counts guard crashes.
// Optional crash autotrigger with a pending re-dump flag: define GUARD_LOG_AUTOTRIG_EN.
module guard_log_reader #(
    parameter int DEPTH  = 6,
    parameter int IDX_W  = 20,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              crash_i,
    output logic [IDX_W-1:0]  rd_index_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       crash_cnt_o
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] CAPT  = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [2:0]        state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [DATA_W-1:0] payload;
    logic              trigger;
    logic              redump;

`ifdef GUARD_LOG_AUTOTRIG_EN
    logic pending;

    assign trigger = start_i | crash_i;
    // A crash landing in the DONE cycle itself is folded into the re-dump that starts now.
    assign redump  = pending | crash_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending <= 1'b0;
        end else if (state == DONE) begin
            pending <= 1'b0;
        end else if (state != IDLE && crash_i) begin
            pending <= 1'b1;
        end
    end
`else
    assign trigger = start_i;
    assign redump  = 1'b0;
`endif

    // NOTE: defaults first so every path assigns the next-state signals; otherwise a latch is inferred.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (trigger) begin
                    idx_nxt   = '0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = CAPT;
            CAPT:  state_nxt = HOLD;
            HOLD: begin
                if (m_ready_i) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + IDX_W'(1);
                        state_nxt = ISSUE;
                    end
                end
            end
            DONE: begin
                if (redump) begin
                    idx_nxt   = '0;
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            idx     <= '0;
            payload <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (state == CAPT) begin
                payload <= rd_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crash_cnt_o <= '0;
        end else if (crash_i && crash_cnt_o != 16'hFFFF) begin
            crash_cnt_o <= crash_cnt_o + 16'd1;
        end
    end

    // Stream outputs decode registered state only, so m_ready_i never reaches them combinationally.
    assign rd_index_o = idx;
    assign m_valid_o  = (state == HOLD);
    assign m_data_o   = payload;
    assign m_last_o   = (state == HOLD) && (idx == LAST_IDX);
    assign busy_o     = (state != IDLE);
    assign done_o     = (state == DONE);

endmodule
